// File: rtl/vga_line_fetch_scheduler.sv
// vga_line_fetch_scheduler
// Shares one single-port frame memory between line fetches for VGA scan-out
// and capture writes. Each LINE_START swaps a ping-pong pair of line buffers
// and starts fetching the next visible line into the back buffer. Capture
// writes are interleaved, and a write waits for at most WR_STARVE_MAX fetch
// reads. The front buffer feeds PIX_DATA.
// Optional build macro: VGA_LINE_UNDERRUN_FILL_EN. When it is defined, each
// buffer keeps a fill count, and any pixel beyond that count shows 8'hE0.
module vga_line_fetch_scheduler #(
    parameter int H_VISIBLE     = 1024,
    parameter int V_VISIBLE     = 600,
    parameter int ADDR_W        = 20,
    parameter int MEM_RD_LAT    = 2,
    parameter int WR_STARVE_MAX = 4
) (
    input  logic              VIDEO_CLK,
    input  logic              RESET,
    input  logic              LINE_START,
    input  logic [11:0]       NEXT_Y,
    input  logic [11:0]       VGA_X_O,
    input  logic              VGA_VISIBLE,
    output logic [7:0]        PIX_DATA,
    input  logic              WR_REQ,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [7:0]        WR_DATA,
    output logic              WR_ACK,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [7:0]        MEM_WDATA,
    output logic              MEM_WE,
    output logic              MEM_RE,
    input  logic [7:0]        MEM_RDATA,
    output logic              FETCH_UNDERRUN
);
    localparam int IDX_W  = 11;
    localparam int BUF_AW = $clog2(H_VISIBLE);
    localparam int SW     = $clog2(WR_STARVE_MAX + 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(H_VISIBLE - 1);
    localparam logic [SW-1:0]    STARVE_MAX = SW'(WR_STARVE_MAX);
    localparam logic [11:0]      V_LIM      = 12'(V_VISIBLE);
    localparam logic [11:0]      H_LIM      = 12'(H_VISIBLE);

    typedef enum logic {ST_IDLE = 1'b0, ST_FETCH = 1'b1} state_e;

    state_e                          state_q, state_d;
    logic [ADDR_W-1:0]               base_q, base_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [SW-1:0]                   starve_q, starve_d;
    logic                            front_q, front_d;
    logic                            underrun_q, underrun_d;
    logic                            wr_ack_q, wr_ack_d;
    logic                            mem_we_q, mem_we_d;
    logic                            mem_re_q, mem_re_d;
    logic [ADDR_W-1:0]               mem_addr_q, mem_addr_d;
    logic [7:0]                      mem_wdata_q, mem_wdata_d;
    logic [7:0]                      pix_q, pix_d;
    logic [MEM_RD_LAT:0]             pv_q, pv_d;
    logic [MEM_RD_LAT:0][BUF_AW-1:0] pidx_q, pidx_d;
    logic [MEM_RD_LAT:0]             pbank_q, pbank_d;
    logic [7:0]                      line_buf_q [2][H_VISIBLE];

    logic              line_ok_s, flush_s, wr_req_s, wr_grant_s, rd_grant_s;
    logic              rd_cand_s, rd_bank_s, lb_we_s, x_in_range_s;
    logic [ADDR_W-1:0] new_base_s, rd_addr_s;
    logic [BUF_AW-1:0] rd_idx_s;

`ifdef VGA_LINE_UNDERRUN_FILL_EN
    localparam logic [7:0] FILL_PIX = 8'hE0;
    logic [1:0][IDX_W-1:0] fill_q, fill_d;
`endif

    // Arbitration: choose at most one memory access (read or write) this cycle
    always_comb begin
        line_ok_s  = (NEXT_Y < V_LIM);
        new_base_s = ADDR_W'(NEXT_Y) * ADDR_W'(H_VISIBLE);
        flush_s    = LINE_START && (state_q == ST_FETCH);
        // The request that was acknowledged last cycle is already served
        wr_req_s   = WR_REQ && !wr_ack_q;
        if (LINE_START) begin
            rd_cand_s = line_ok_s;
            rd_addr_s = new_base_s;
            rd_idx_s  = '0;
            rd_bank_s = front_q;
        end else begin
            rd_cand_s = (state_q == ST_FETCH);
            rd_addr_s = base_q + ADDR_W'(idx_q);
            rd_idx_s  = idx_q[BUF_AW-1:0];
            rd_bank_s = ~front_q;
        end
        if (wr_req_s && (LINE_START || !rd_cand_s || (starve_q == STARVE_MAX))) begin
            wr_grant_s = 1'b1;
        end else begin
            wr_grant_s = 1'b0;
        end
        rd_grant_s = rd_cand_s && !wr_grant_s;
    end

    // Next-state logic for the fetch FSM, starve counter, outputs and tag pipeline
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        idx_d       = idx_q;
        front_d     = front_q;
        underrun_d  = underrun_q;
        if (LINE_START) begin
            front_d = ~front_q;
            if (flush_s) begin
                underrun_d = 1'b1;
            end else begin
                underrun_d = underrun_q;
            end
            base_d  = new_base_s;
            idx_d   = rd_grant_s ? IDX_W'(1) : '0;
            state_d = line_ok_s ? ST_FETCH : ST_IDLE;
        end else if ((state_q == ST_FETCH) && rd_grant_s) begin
            if (idx_q == LAST_IDX) begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = ST_FETCH;
            end
        end else begin
            idx_d = idx_q;
        end

        if (!WR_REQ) begin
            starve_d = '0;
        end else if (wr_grant_s) begin
            starve_d = '0;
        end else if (rd_grant_s && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end

        wr_ack_d    = wr_grant_s;
        mem_we_d    = wr_grant_s;
        mem_re_d    = rd_grant_s;
        mem_wdata_d = wr_grant_s ? WR_DATA : mem_wdata_q;
        if (wr_grant_s) begin
            mem_addr_d = WR_ADDR;
        end else if (rd_grant_s) begin
            mem_addr_d = rd_addr_s;
        end else begin
            mem_addr_d = mem_addr_q;
        end

        // Stage 0 tags the read issued now; an aborted fetch drops older stages
        pv_d[0]    = rd_grant_s;
        pidx_d[0]  = rd_idx_s;
        pbank_d[0] = rd_bank_s;
        for (int i = 1; i <= MEM_RD_LAT; i++) begin
            pv_d[i]    = pv_q[i-1] && !flush_s;
            pidx_d[i]  = pidx_q[i-1];
            pbank_d[i] = pbank_q[i-1];
        end
    end

    // Pixel output: front buffer lookup, blanked outside active video
    always_comb begin
        lb_we_s      = pv_q[MEM_RD_LAT];
        x_in_range_s = (VGA_X_O < H_LIM);
        if (!VGA_VISIBLE || !x_in_range_s) begin
            pix_d = 8'h00;
`ifdef VGA_LINE_UNDERRUN_FILL_EN
        end else if (VGA_X_O >= 12'(fill_q[front_q])) begin
            pix_d = FILL_PIX;
`endif
        end else begin
            pix_d = line_buf_q[front_q][VGA_X_O[BUF_AW-1:0]];
        end
    end

`ifdef VGA_LINE_UNDERRUN_FILL_EN
    // Fill counts: a bank becomes empty when it turns into the back buffer
    always_comb begin
        fill_d = fill_q;
        if (lb_we_s) begin
            fill_d[pbank_q[MEM_RD_LAT]] = fill_q[pbank_q[MEM_RD_LAT]] + IDX_W'(1);
        end else begin
            fill_d = fill_q;
        end
        if (LINE_START) begin
            fill_d[front_q] = '0;
        end else begin
            fill_d[~front_q] = fill_d[~front_q];
        end
    end

    // Fill count registers
    always_ff @(posedge VIDEO_CLK) begin
        if (RESET) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end
`endif

    // FSM state, registered memory/handshake outputs and read-tag pipeline
    always_ff @(posedge VIDEO_CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            idx_q       <= '0;
            starve_q    <= '0;
            front_q     <= 1'b0;
            underrun_q  <= 1'b0;
            wr_ack_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            pix_q       <= 8'h00;
            pv_q        <= '0;
            pidx_q      <= '0;
            pbank_q     <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            idx_q       <= idx_d;
            starve_q    <= starve_d;
            front_q     <= front_d;
            underrun_q  <= underrun_d;
            wr_ack_q    <= wr_ack_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            pix_q       <= pix_d;
            pv_q        <= pv_d;
            pidx_q      <= pidx_d;
            pbank_q     <= pbank_d;
        end
    end

    // Line buffer storage: returned read data lands in its tagged bank and index
    always_ff @(posedge VIDEO_CLK) begin
        if (!RESET && lb_we_s) begin
            line_buf_q[pbank_q[MEM_RD_LAT]][pidx_q[MEM_RD_LAT]] <= MEM_RDATA;
        end
    end

    assign PIX_DATA       = pix_q;
    assign WR_ACK         = wr_ack_q;
    assign MEM_ADDR       = mem_addr_q;
    assign MEM_WDATA      = mem_wdata_q;
    assign MEM_WE         = mem_we_q;
    assign MEM_RE         = mem_re_q;
    assign FETCH_UNDERRUN = underrun_q;

endmodule

// File: tb/tb_vga_line_fetch_scheduler.sv
// Directed testbench for vga_line_fetch_scheduler (default build).
// The memory model returns data two cycles after MEM_RE. The returned data is
// addr[7:0], or addr[7:0] ^ addr[17:10] when mem_mix is set.
module tb_vga_line_fetch_scheduler;
    localparam int ADDR_W = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              line_start;
    logic [11:0]       next_y;
    logic [11:0]       vga_x;
    logic              vga_vis;
    logic [7:0]        pix_data;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_rdata = 8'h00;
    logic              fetch_underrun;
    logic [7:0]        rd_p1 = 8'h00;
    logic              mem_mix = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int f_reads, f_first, f_last, f_addr_errs, f_writes, f_wr_errs, f_both;
    int pix_errs, cnt;

    logic [ADDR_W-1:0] wa_tab [4] = '{20'h00000, 20'hFFFFF, 20'h12345, 20'h80001};
    logic [7:0]        wd_tab [4] = '{8'h00, 8'hFF, 8'hA5, 8'h5A};

    vga_line_fetch_scheduler dut (
        .VIDEO_CLK      (clk),
        .RESET          (rst),
        .LINE_START     (line_start),
        .NEXT_Y         (next_y),
        .VGA_X_O        (vga_x),
        .VGA_VISIBLE    (vga_vis),
        .PIX_DATA       (pix_data),
        .WR_REQ         (wr_req),
        .WR_ADDR        (wr_addr),
        .WR_DATA        (wr_data),
        .WR_ACK         (wr_ack),
        .MEM_ADDR       (mem_addr),
        .MEM_WDATA      (mem_wdata),
        .MEM_WE         (mem_we),
        .MEM_RE         (mem_re),
        .MEM_RDATA      (mem_rdata),
        .FETCH_UNDERRUN (fetch_underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_model(input logic [ADDR_W-1:0] a, input logic mix);
        return mix ? (a[7:0] ^ a[17:10]) : a[7:0];
    endfunction

    // Two-cycle read latency memory model
    always @(posedge clk) begin
        rd_p1     <= mem_re ? mem_model(mem_addr, mem_mix) : 8'h00;
        mem_rdata <= rd_p1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Observe a fetch for line y; handles write acks when wr_req is held high
    task automatic run_fetch(input int y, input int max_cyc);
        f_reads = 0; f_first = 0; f_last = 0; f_addr_errs = 0;
        f_writes = 0; f_wr_errs = 0; f_both = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            line_start = 1'b0;
            if (mem_re && mem_we) f_both++;
            if (mem_re) begin
                if (mem_addr !== ADDR_W'(y * 1024 + f_reads)) f_addr_errs++;
                if (f_reads == 0) f_first = c;
                f_reads++;
                f_last = c;
            end
            if (wr_ack) begin
                if (!mem_we || (mem_addr !== wr_addr) || (mem_wdata !== wr_data) ||
                    (((c - 1) % 5) != 0)) f_wr_errs++;
                f_writes++;
                wr_addr = wr_addr + 20'd1;
                wr_data = wr_data + 8'd3;
            end
            if (f_reads == 1024) begin
                wr_req = 1'b0;
                break;
            end
        end
    endtask

    // Sweep x = 0..n-1 and compare PIX_DATA one cycle later against (x ^ key)
    task automatic scan_pix(input int n, input int key, output int errs);
        errs = 0;
        for (int x = 0; x <= n; x++) begin
            @(negedge clk);
            if ((x > 0) && (pix_data !== (8'(x - 1) ^ 8'(key)))) errs++;
            if (x < n) begin
                vga_x   = 12'(x);
                vga_vis = 1'b1;
            end else begin
                vga_x   = 12'd0;
                vga_vis = 1'b0;
            end
        end
        @(negedge clk);
        check_val("pix_blank", 32'(pix_data), 32'h0);
    endtask

    task automatic count_re(input int ncyc, output int n);
        n = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            line_start = 1'b0;
            if (mem_re) n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; line_start = 1'b0; next_y = 12'd0; vga_x = 12'd0; vga_vis = 1'b0;
        wr_req = 1'b0; wr_addr = 20'd0; wr_data = 8'd0;
        repeat (3) @(negedge clk);
        check_val("rst_pix", 32'(pix_data), 32'h0);
        check_val("rst_ack", 32'(wr_ack), 32'h0);
        check_val("rst_we", 32'(mem_we), 32'h0);
        check_val("rst_re", 32'(mem_re), 32'h0);
        check_val("rst_addr", 32'(mem_addr), 32'h0);
        check_val("rst_wdata", 32'(mem_wdata), 32'h0);
        check_val("rst_underrun", 32'(fetch_underrun), 32'h0);
        rst = 1'b0;

        // Plain fetch of line 5: reads 5120..6143, first read right after LINE_START
        @(negedge clk);
        line_start = 1'b1; next_y = 12'd5;
        run_fetch(5, 1100);
        check_val("y5_reads", 32'(f_reads), 32'd1024);
        check_val("y5_first", 32'(f_first), 32'd1);
        check_val("y5_last", 32'(f_last), 32'd1024);
        check_val("y5_addr_errs", 32'(f_addr_errs), 32'd0);
        @(negedge clk);
        check_val("y5_re_done", 32'(mem_re), 32'h0);

        // Suppressed line: swap only, no reads
        line_start = 1'b1; next_y = 12'd600;
        count_re(40, cnt);
        check_val("y600_no_re", 32'(cnt), 32'd0);
        scan_pix(1024, 0, pix_errs);
        check_val("y5_pix_errs", 32'(pix_errs), 32'd0);

        // Writes with FSM idle: granted immediately, one at a time
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            wr_req = 1'b1; wr_addr = wa_tab[k]; wr_data = wd_tab[k];
            @(negedge clk);
            check_val("idle_ack", 32'(wr_ack), 32'h1);
            check_val("idle_we", 32'(mem_we), 32'h1);
            check_val("idle_addr", 32'(mem_addr), 32'(wa_tab[k]));
            check_val("idle_wdata", 32'(mem_wdata), 32'(wd_tab[k]));
            check_val("idle_re", 32'(mem_re), 32'h0);
            wr_req = 1'b0;
            @(negedge clk);
            check_val("idle_ack_drop", 32'(wr_ack), 32'h0);
        end

        // Fetch of line 7 with WR_REQ held high from the LINE_START cycle
        @(negedge clk);
        line_start = 1'b1; next_y = 12'd7;
        wr_req = 1'b1; wr_addr = 20'h40000; wr_data = 8'h10;
        run_fetch(7, 1400);
        check_val("wr_reads", 32'(f_reads), 32'd1024);
        check_val("wr_first_rd", 32'(f_first), 32'd2);
        check_val("wr_last_rd", 32'(f_last), 32'd1280);
        check_val("wr_count", 32'(f_writes), 32'd256);
        check_val("wr_errs", 32'(f_wr_errs), 32'd0);
        check_val("wr_addr_errs", 32'(f_addr_errs), 32'd0);
        check_val("wr_collide", 32'(f_both), 32'd0);
        check_val("wr_underrun", 32'(fetch_underrun), 32'h0);

        // Truncated fetch: line 10 aborted after 600 cycles by LINE_START for line 20
        mem_mix = 1'b1;
        @(negedge clk);
        line_start = 1'b1; next_y = 12'd10;
        run_fetch(10, 600);
        check_val("y10_reads", 32'(f_reads), 32'd600);
        check_val("y10_no_underrun", 32'(fetch_underrun), 32'h0);
        line_start = 1'b1; next_y = 12'd20;
        run_fetch(20, 1100);
        check_val("underrun_set", 32'(fetch_underrun), 32'h1);
        check_val("y20_reads", 32'(f_reads), 32'd1024);
        check_val("y20_first", 32'(f_first), 32'd1);
        check_val("y20_addr_errs", 32'(f_addr_errs), 32'd0);
        scan_pix(598, 10, pix_errs);
        check_val("y10_part_pix_errs", 32'(pix_errs), 32'd0);
        @(negedge clk);
        line_start = 1'b1; next_y = 12'd600;
        @(negedge clk);
        line_start = 1'b0;
        scan_pix(1024, 20, pix_errs);
        check_val("y20_pix_errs", 32'(pix_errs), 32'd0);
        check_val("underrun_sticky", 32'(fetch_underrun), 32'h1);

        // Reset during a fetch
        @(negedge clk);
        line_start = 1'b1; next_y = 12'd3;
        count_re(10, cnt);
        check_val("y3_reading", 32'(mem_re), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_mid_re", 32'(mem_re), 32'h0);
        check_val("rst_mid_underrun", 32'(fetch_underrun), 32'h0);
        rst = 1'b0;
        count_re(30, cnt);
        check_val("rst_mid_idle", 32'(cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vga_line_fetch_scheduler.md
# vga_line_fetch_scheduler

Sequences a single-port external frame memory between the VGA scan-out path and the capture write path. Each line it fetches the next visible line into a ping-pong pair of internal 1024×8 line buffers and interleaves capture writes under a bounded-starvation rule. The front buffer serves pixel data to the VGA output stage. It sits between the VGA timing generator (coordinates, line-start pulse) and the SRAM pins.

## Interface
- H_VISIBLE, 1024, pixels per line; line buffer depth.
- V_VISIBLE, 600, visible lines; fetches for Y ≥ V_VISIBLE are suppressed.
- ADDR_W, 20, memory address width.
- MEM_RD_LAT, 2, cycles from MEM_RE to valid MEM_RDATA; fixed.
- WR_STARVE_MAX, 4, maximum consecutive fetch grants while a write is pending.
- Reset is RESET, synchronous, active-high; clock is VIDEO_CLK.
- VIDEO_CLK  in  1  pixel clock; all logic on posedge.
- RESET  in  1  synchronous active-high reset.
- LINE_START  in  1  one-cycle pulse at start of each line's blanking.
- NEXT_Y  in  12  visible line number to be displayed after the next LINE_START; sampled with LINE_START.
- VGA_X_O  in  12  active-region x coordinate.
- VGA_VISIBLE  in  1  high in active video.
- PIX_DATA  out  8  pixel for VGA_X_O, registered.
- WR_REQ  in  1  capture write request; held until WR_ACK.
- WR_ADDR  in  ADDR_W  capture write address.
- WR_DATA  in  8  capture write data.
- WR_ACK  out  1  one-cycle pulse: write issued this cycle.
- MEM_ADDR  out  ADDR_W  memory address.
- MEM_WDATA  out  8  memory write data.
- MEM_WE  out  1  memory write strobe.
- MEM_RE  out  1  memory read strobe.
- MEM_RDATA  in  8  memory read data.
- FETCH_UNDERRUN  out  1  sticky: a line fetch was truncated.

## Operation
- FSM states: IDLE, FETCH. Reset → IDLE.
- IDLE: on LINE_START with NEXT_Y < V_VISIBLE, latch base = NEXT_Y·H_VISIBLE, fetch index = 0, swap front/back, → FETCH. With NEXT_Y ≥ V_VISIBLE: swap only and stay IDLE.
- FETCH: issue one read per granted cycle, MEM_ADDR = base + index, index++. After index H_VISIBLE−1 is issued → IDLE. Returning data is written to back buffer at the tag carried through a MEM_RD_LAT-deep valid/index pipeline.
- Arbitration each cycle, one memory access maximum: FETCH with no WR_REQ → read. WR_REQ in IDLE → write. WR_REQ in FETCH → read unless the starve counter = WR_STARVE_MAX, then write and clear the counter. The starve counter increments on each read granted while WR_REQ is high and clears when WR_REQ is low.
- Write grant: MEM_WE=1, MEM_ADDR=WR_ADDR, MEM_WDATA=WR_DATA, WR_ACK=1 in the same cycle.
- LINE_START while in FETCH: abort remaining reads, flush the in-flight pipeline (late returns discarded), set FETCH_UNDERRUN, then perform the normal LINE_START action.
- Pixel path: PIX_DATA ← front[VGA_X_O[9:0]] when VGA_VISIBLE, else 0.
- Base address arithmetic is ADDR_W-bit unsigned; the index is 11 bits and never wraps past H_VISIBLE−1.
- Reset values: PIX_DATA=0, WR_ACK=0, MEM_WE=0, MEM_RE=0, MEM_ADDR=0, MEM_WDATA=0, FETCH_UNDERRUN=0, front=buffer 0, pipeline empty. Line buffer contents are not reset.
- RESET mid-fetch: immediate return to IDLE; in-flight returns are discarded.

## Timing
- Pixel latency: VGA_X_O at cycle n → PIX_DATA at n+1.
- Fetch with no writes: 1024 consecutive reads, first read the cycle after LINE_START. With continuous WR_REQ: one write per WR_STARVE_MAX+1 cycles, so fetch completes in 1280 cycles (< 1312-cycle line).
- Buffer written at cycle t+MEM_RD_LAT for a read issued at t.
- WR_ACK latency: same cycle as grant. With no fetch active, a write is granted the first cycle WR_REQ is sampled high.
- Simultaneous LINE_START and WR_REQ in IDLE: the write is granted this cycle, and FETCH begins next cycle.

## Configuration
- VGA_LINE_UNDERRUN_FILL_EN defined: each buffer records its fill count. Pixels with VGA_X_O ≥ fill count of the front buffer output 8'hE0. A count of 0 for a suppressed line outputs fill for the whole line.
- Undefined: no fill count is kept, and unfetched pixels show stale buffer data.

## Test plan
- Reset, LINE_START with NEXT_Y=5, memory model data = addr[7:0] → 1024 reads at addresses 5120..6143. After the next LINE_START, PIX_DATA for X=0..1023 = 8'h00..8'hFF repeating, one cycle after VGA_X_O.
- WR_REQ held high during fetch → WR_ACK every 5th cycle and fetch done in 1280 cycles. Each write appears on MEM_WE with the exact WR_ADDR/WR_DATA. FETCH_UNDERRUN=0.
- Write requests only, FSM in IDLE → every request is granted immediately, and MEM_RE stays 0.
- Second LINE_START 600 cycles after the first → FETCH_UNDERRUN=1. Late returns do not corrupt the new back buffer. With the fill macro, pixels at X ≥ 600 = 8'hE0.
- NEXT_Y=600 → no MEM_RE for that line. RESET asserted mid-fetch → MEM_RE=0 next cycle, FSM IDLE, FETCH_UNDERRUN=0.
